// File: rtl/ram_port_arbiter.sv
// Purpose : round-robin share of one single-port synchronous RAM among NUM_REQ requesters.
// Latency : grant is combinational; read data is returned exactly 1 cycle after its grant.
// Backpr. : an unaccepted response is parked in hold_reg (HOLD); no new grants until it is taken.
//
// Ports:
//   clk, reset              - clock; synchronous active-high reset
//   req_valid/wen/addr/wdata- per-requester access request (addr/wdata packed, requester i at slice i)
//   req_ready               - one-hot grant, request accepted this cycle
//   rsp_valid/rsp_data      - one-hot read-response valid and its data
//   rsp_ready               - requester accepts the response
//   ram_wEn/addr/dataIn     - RAM command, driven combinationally from the winner
//   ram_dataOut             - RAM registered read data
// Optional: define RAM_ARB_PERF_EN to add perf_grants / perf_hold_cycles counters.
module ram_port_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_wen,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic                             ram_wEn,
  output logic [ADDRESS_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_dataIn,
  input  logic [DATA_WIDTH-1:0]            ram_dataOut
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [31:0]                      perf_grants,
  output logic [31:0]                      perf_hold_cycles
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_DATA = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]        rsp_id, rsp_id_nxt;
  logic [DATA_WIDTH-1:0]   hold_reg, hold_nxt;
  logic [PTR_W-1:0]        cand;
  logic [PTR_W-1:0]        win_idx;
  logic                    win_vld;
  logic                    owner_rdy;
  logic                    gnt_ok;
  logic                    gnt;

  // Rotating priority scan: first valid requester at or after rr_ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign owner_rdy = rsp_ready[rsp_id];

  // The RAM output register only survives one cycle, so a new access may
  // start only when no response is owed or the owed one is taken right now.
  // Reset gating also suppresses a write presented during reset.
  assign gnt_ok = !reset && ((state == IDLE) || ((state == RD_DATA) && owner_rdy));
  assign gnt    = win_vld && gnt_ok;

  // RAM drive and grant
  always_comb begin
    req_ready  = '0;
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    if (gnt) begin
      req_ready[win_idx] = 1'b1;
      ram_wEn            = req_wen[win_idx];
      ram_addr           = req_addr[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      ram_dataIn         = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Response drive: live RAM output in RD_DATA, parked copy in HOLD.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (!reset) begin
      case (state)
        RD_DATA: begin
          rsp_valid[rsp_id] = 1'b1;
          rsp_data          = ram_dataOut;
        end
        HOLD: begin
          rsp_valid[rsp_id] = 1'b1;
          rsp_data          = hold_reg;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    rsp_id_nxt = rsp_id;
    hold_nxt   = hold_reg;
    rr_ptr_nxt = rr_ptr;

    if (gnt) begin
      rr_ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    case (state)
      IDLE: begin
        if (gnt && !req_wen[win_idx]) begin
          state_nxt  = RD_DATA;
          rsp_id_nxt = win_idx;
        end
      end
      RD_DATA: begin
        if (owner_rdy) begin
          if (gnt && !req_wen[win_idx]) begin
            state_nxt  = RD_DATA;
            rsp_id_nxt = win_idx;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          // RAM output will be overwritten next cycle; keep our copy.
          hold_nxt  = ram_dataOut;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (owner_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      rsp_id   <= '0;
      hold_reg <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      rsp_id   <= rsp_id_nxt;
      hold_reg <= hold_nxt;
    end
  end

`ifdef RAM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grants      <= '0;
      perf_hold_cycles <= '0;
    end else begin
      if (gnt) begin
        perf_grants <= perf_grants + 32'd1;
      end
      if (state == HOLD) begin
        perf_hold_cycles <= perf_hold_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous RAM (1-cycle registered read, read-or-write per cycle) among NUM_REQ requesters, e.g. fetch, LSU and debug loader.
- Grants at most one access per cycle, drives the RAM port and returns read data to the owning requester with a valid/ready handshake.
- Buffers read data in a hold register under back-pressure, because the RAM's read output changes on every non-write cycle.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, RAM word width
ADDRESS_WIDTH, 12, RAM address width

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester access request
req_wen  input  NUM_REQ  1 = write, 0 = read
req_addr  input  NUM_REQ*ADDRESS_WIDTH  packed addresses, requester i at slice i
req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data
req_ready  output  NUM_REQ  one-hot grant; request accepted this cycle
rsp_valid  output  NUM_REQ  one-hot read-response valid
rsp_data  output  DATA_WIDTH  read data for the flagged requester
rsp_ready  input  NUM_REQ  requester accepts the response
ram_wEn  output  1  RAM write enable
ram_addr  output  ADDRESS_WIDTH  RAM address
ram_dataIn  output  DATA_WIDTH  RAM write data
ram_dataOut  input  DATA_WIDTH  RAM registered read data

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: state=IDLE, rr_ptr=0, rsp_id=0, hold_reg=0.
- Outputs during reset: rsp_valid=0, req_ready=0, ram_wEn=0, ram_addr=0, ram_dataIn=0.
- Arbitration:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit i wins.
  - On a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Grant allowed only when:
  - state==IDLE; or
  - state==RD_DATA and rsp_ready[rsp_id]==1.
- RAM drive is combinational from the winner:
  - Grant to i: ram_wEn=req_wen[i], ram_addr=req_addr slice i, ram_dataIn=req_wdata slice i, req_ready[i]=1.
  - No grant: ram_wEn=0, ram_addr=0, ram_dataIn=0, req_ready=0.
- Requesters hold valid/wen/addr/wdata stable until req_ready. They may drop req_valid before grant, with no side effect.
- FSM:
  - IDLE: no response owed.
    - Read granted to i: rsp_id<=i, go to RD_DATA.
    - Write granted or no grant: stay in IDLE.
  - RD_DATA: rsp_valid[rsp_id]=1, rsp_data=ram_dataOut. Read latency is exactly 1 cycle from grant.
    - rsp_ready[rsp_id]=1: a new grant is allowed this cycle. New read goes to RD_DATA with the new rsp_id; otherwise go to IDLE.
    - rsp_ready[rsp_id]=0: hold_reg<=ram_dataOut, no grant, go to HOLD.
  - HOLD: rsp_valid[rsp_id]=1, rsp_data=hold_reg, no grant.
    - rsp_ready[rsp_id]=1: go to IDLE; no grant in the same cycle.
- Writes produce no response. They are visible to any read granted in a later cycle, so read-after-write from different requesters returns the new data.
- Throughput: one access per cycle while responses are accepted immediately.
- Reset mid-operation: a pending response is dropped; state returns to IDLE and rr_ptr to 0. A write granted in the same cycle as reset is suppressed, because ram_wEn is gated by reset.
- A requester with a response pending may issue again once its response is accepted. Back-to-back reads by the same requester are legal.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- Defined: adds outputs perf_grants[31:0] and perf_hold_cycles[31:0].
  - perf_grants: +1 per grant (reads and writes).
  - perf_hold_cycles: +1 per cycle spent in HOLD.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Write then read, same requester: r0 writes 0xDEADBEEF to 0x010 (cycle 0), reads 0x010 (cycle 1) -> rsp_valid[0] and rsp_data=0xDEADBEEF in cycle 2; no response for the write.
- Contention, rsp_ready all 1: r0 and r1 both read continuously from reset -> grants r0,r1,r0,r1 on consecutive cycles, one rsp_valid per cycle, one cycle after each grant, correct id each time.
- Back-pressure: r1 reads 0x0A5 (holding 0x12345678) with rsp_ready[1]=0 for 3 cycles -> state RD_DATA then HOLD; rsp_data stays 0x12345678 every cycle; no req_ready while waiting; IDLE the cycle after rsp_ready[1]=1.
- Cross-requester ordering: r0 writes 0x55 to 0x3FF while r1 reads 0x3FF, rr_ptr=0 -> r0 granted first, r1 next cycle; r1 receives 0x00000055.
- Reset mid-read: assert reset in RD_DATA cycle -> next cycle rsp_valid=0, req_ready=0, rr_ptr=0, RAM contents unchanged.
- RAM_ARB_PERF_EN: 5 grants plus 2 HOLD cycles -> perf_grants=5, perf_hold_cycles=2; both 0 after reset.
